// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the AES-256 inverse cipher datapath: walks LOAD, ARK, ISR, ISB, IMC
// and drives the stage write enables, operand selects and the round-key index.
module aes_dec_round_ctrl #(
  parameter int NR = 14
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       key_valid,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       busy,
  output logic [3:0] round,
  output logic [3:0] key_idx,
  output logic       ld_en,
  output logic       ark_en,
  output logic       isr_en,
  output logic       isb_en,
  output logic       imc_en,
  output logic       ark_src,
  output logic       isr_src
);

  localparam logic [3:0] NR_U = 4'(NR);

  // One-hot encoding so every stage enable is a single state flop.
  typedef enum logic [6:0] {
    IDLE = 7'b000_0001,
    LOAD = 7'b000_0010,
    ARK  = 7'b000_0100,
    ISR  = 7'b000_1000,
    ISB  = 7'b001_0000,
    IMC  = 7'b010_0000,
    DONE = 7'b100_0000
  } state_t;

  state_t     state;
  logic [3:0] round_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      round_q <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state   <= LOAD;
            round_q <= 4'd0;
          end
        end
        LOAD: state <= ARK;
        ARK: begin
          // Wait here for the key schedule; round and key_idx stay frozen meanwhile.
          if (key_valid) begin
            if (round_q == NR_U) begin
              state <= DONE;
            end else if (round_q == 4'd0) begin
              state   <= ISR;
              round_q <= round_q + 4'd1;
            end else begin
              state <= IMC;
            end
          end
        end
        ISR: state <= ISB;
        ISB: state <= ARK;
        IMC: begin
          state   <= ISR;
          round_q <= round_q + 4'd1;
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            round_q <= 4'd0;
          end
        end
        default: begin
          state   <= IDLE;
          round_q <= 4'd0;
        end
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == DONE);
  assign ld_en       = (state == LOAD);
  assign ark_en      = (state == ARK) & key_valid;
  assign isr_en      = (state == ISR);
  assign isb_en      = (state == ISB);
  assign imc_en      = (state == IMC);
  assign round       = round_q;
  assign key_idx     = NR_U - round_q;
  // First round adds key to the raw ciphertext; first InvShiftRows skips InvMixColumns.
  assign ark_src     = (round_q != 4'd0);
  assign isr_src     = (round_q != 4'd1);

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: drives an AES-256 datapath model from the enables and
// compares against a software inverse cipher and the expected cycle timing.
module tb_aes_dec_round_ctrl;
  localparam int NR  = 14;
  localparam int LAT = 4 * NR + 1;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_valid = 1'b0;
  logic       key_valid = 1'b1;
  logic       out_ready = 1'b1;
  logic       start_ready, out_valid, busy;
  logic [3:0] round, key_idx;
  logic       ld_en, ark_en, isr_en, isb_en, imc_en, ark_src, isr_src;

  aes_dec_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .resetn(resetn), .start_valid(start_valid), .start_ready(start_ready),
    .key_valid(key_valid), .out_ready(out_ready), .out_valid(out_valid), .busy(busy),
    .round(round), .key_idx(key_idx), .ld_en(ld_en), .ark_en(ark_en), .isr_en(isr_en),
    .isb_en(isb_en), .imc_en(imc_en), .ark_src(ark_src), .isr_src(isr_src)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // AES arithmetic and tables
  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [15];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, rc;
    logic [31:0] w[60];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < 8) w[i] = FIPS_KEY[255 - 32 * i -: 32];
      else begin
        t = w[i - 1];
        if (i % 8 == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (i % 8 == 4) t = subword(t);
        w[i] = w[i - 8] ^ t;
      end
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] inv_shift(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127 - 8 * (r + 4 * c) -: 8] = v[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127 - 8 * n -: 8] = isbox[v[127 - 8 * n -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0] a[4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = v[127 - 8 * (r + 4 * c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (r + 4 * c) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r + 1) % 4], 8'h0b) ^
                                        gmul(a[(r + 2) % 4], 8'h0d) ^ gmul(a[(r + 3) % 4], 8'h09);
    end
    return o;
  endfunction

  // Straight FIPS-197 inverse cipher used as the reference for random ciphertexts.
  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ rk[r]);
    return inv_sub(inv_shift(s)) ^ rk[0];
  endfunction

  // Datapath model clocked by the DUT's enables, plus activity bookkeeping
  logic [127:0] ct_cur = '0;
  logic [127:0] in_r = '0, ark_r = '0, isr_r = '0, isb_r = '0, imc_r = '0;
  int n_ld, n_ark, n_isr, n_isb, n_imc, n_stall, onehot_bad, sel_bad, hot;
  int kidx_q[$];

  always @(negedge clk) begin
    if (resetn) begin
      hot = int'(ld_en) + int'(ark_en) + int'(isr_en) + int'(isb_en) + int'(imc_en);
      if (hot > 1) onehot_bad++;
      if (busy && !ld_en && !ark_en && !isr_en && !isb_en && !imc_en && !out_valid) n_stall++;
      if (ld_en) begin
        n_ld++;
        in_r = ct_cur;
      end
      if (ark_en) begin
        n_ark++;
        kidx_q.push_back(int'(key_idx));
        if (ark_src !== (round != 4'd0)) sel_bad++;
        if (int'(key_idx) + int'(round) != NR) sel_bad++;
        ark_r = (ark_src ? isb_r : in_r) ^ rk[key_idx];
      end
      if (isr_en) begin
        n_isr++;
        if (isr_src !== (round != 4'd1)) sel_bad++;
        isr_r = inv_shift(isr_src ? imc_r : ark_r);
      end
      if (isb_en) begin
        n_isb++;
        isb_r = inv_sub(isr_r);
      end
      if (imc_en) begin
        n_imc++;
        imc_r = inv_mix(ark_r);
      end
    end
  end

  task automatic clear_mon();
    n_ld = 0; n_ark = 0; n_isr = 0; n_isb = 0; n_imc = 0;
    n_stall = 0; onehot_bad = 0; sel_bad = 0;
    kidx_q.delete();
  endtask

  // Raise start_valid until LOAD is seen; t_acc is the acceptance edge, -1 on timeout.
  task automatic start_op(input logic [127:0] ct, output int t_acc);
    int n;
    ct_cur = ct;
    clear_mon();
    start_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ld_en && n < 100);
    start_valid = 1'b0;
    t_acc = ld_en ? cyc : -1;
  endtask

  task automatic wait_done(input int t_acc, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1; n++;
    end
    lat = out_valid ? cyc - t_acc : -1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({ld_en, ark_en, isr_en, isb_en, imc_en, out_valid, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_enables: got %b want 0000000",
               {ld_en, ark_en, isr_en, isb_en, imc_en, out_valid, busy});
    end
    total++;
    if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
    total++;
    if (round !== 4'd0) begin bad++; $display("FAIL reset_round: got %0d want 0", round); end
    total++;
    if (key_idx !== 4'(NR)) begin bad++; $display("FAIL reset_key_idx: got %0d want %0d", key_idx, NR); end
    start_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_hold: got busy=%b want 0", busy); end
    start_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t, lat;
    bit ok;
    key_valid = 1'b1; out_ready = 1'b1;
    start_op(FIPS_CT, t);
    wait_done(t, lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (ark_r !== FIPS_PT) begin bad++; $display("FAIL basic_plaintext: got %h want %h", ark_r, FIPS_PT); end
    total++;
    if (start_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_done: got %b want 0", start_ready); end
    total++;
    if ({n_ld, n_ark, n_isr, n_isb, n_imc} !== {32'd1, 32'(NR + 1), 32'(NR), 32'(NR), 32'(NR - 1)}) begin
      bad++;
      $display("FAIL basic_pulse_counts: got ld=%0d ark=%0d isr=%0d isb=%0d imc=%0d want 1 %0d %0d %0d %0d",
               n_ld, n_ark, n_isr, n_isb, n_imc, NR + 1, NR, NR, NR - 1);
    end
    ok = (kidx_q.size() == NR + 1);
    if (ok) for (int i = 0; i <= NR; i++) if (kidx_q[i] != NR - i) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_key_idx_seq: got %0d entries want %0d..0", kidx_q.size(), NR); end
    total++;
    if (sel_bad !== 0) begin bad++; $display("FAIL basic_selects: got %0d bad selects want 0", sel_bad); end
    @(posedge clk); #1;
    total++;
    if ({out_valid, start_ready, round} !== {1'b0, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL basic_exit: got out_valid=%b start_ready=%b round=%0d want 0 1 0", out_valid, start_ready, round);
    end
  endtask

  task automatic test_key_stall();
    int t, lat, n;
    logic [127:0] ct;
    ct = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1; out_ready = 1'b1;
    start_op(ct, t);
    n = 0;
    while (!(ark_en && round == 4'd5) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    key_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({ark_en, round, key_idx} !== {1'b0, 4'd5, 4'd9}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got ark_en=%b round=%0d key_idx=%0d want 0 5 9", i, ark_en, round, key_idx);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    key_valid = 1'b1;
    wait_done(t, lat);
    total++;
    if (lat !== LAT + 3) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, LAT + 3); end
    total++;
    if (ark_r !== aes_dec(ct)) begin bad++; $display("FAIL stall_plaintext: got %h want %h", ark_r, aes_dec(ct)); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_hold();
    int t, lat;
    key_valid = 1'b1; out_ready = 1'b0;
    start_op(FIPS_CT, t);
    wait_done(t, lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL hold_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, start_ready} !== 2'b10) begin
        bad++;
        $display("FAIL hold_cycle[%0d]: got out_valid=%b start_ready=%b want 1 0", i, out_valid, start_ready);
      end
      if (i == 4) start_valid = 1'b1;
      if (i == 6) start_valid = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (ark_r !== FIPS_PT) begin bad++; $display("FAIL hold_plaintext: got %h want %h", ark_r, FIPS_PT); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, start_ready} !== 2'b01) begin
      bad++;
      $display("FAIL hold_release: got out_valid=%b start_ready=%b want 0 1", out_valid, start_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, ld_en} !== 2'b00) begin bad++; $display("FAIL hold_start_ignored: got busy=%b ld_en=%b want 0 0", busy, ld_en); end
  endtask

  task automatic test_reset_mid();
    int t, lat, n;
    logic [127:0] ct;
    key_valid = 1'b1; out_ready = 1'b1;
    start_op(FIPS_CT, t);
    n = 0;
    while (!(isb_en && round == 4'd7) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (isb_en !== 1'b1) begin bad++; $display("FAIL midreset_reach: got isb_en=%b round=%0d want 1 7", isb_en, round); end
    #1 resetn = 1'b0;
    #1;
    total++;
    if ({ld_en, ark_en, isr_en, isb_en, imc_en, out_valid, busy, start_ready} !== 8'b0000_0001) begin
      bad++;
      $display("FAIL midreset_outputs: got %b want 00000001",
               {ld_en, ark_en, isr_en, isb_en, imc_en, out_valid, busy, start_ready});
    end
    total++;
    if ({round, key_idx} !== {4'd0, 4'(NR)}) begin
      bad++;
      $display("FAIL midreset_round: got round=%0d key_idx=%0d want 0 %0d", round, key_idx, NR);
    end
    @(negedge clk); #1 resetn = 1'b1;
    ct = {$urandom, $urandom, $urandom, $urandom};
    start_op(ct, t);
    wait_done(t, lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (ark_r !== aes_dec(ct)) begin bad++; $display("FAIL midreset_plaintext: got %h want %h", ark_r, aes_dec(ct)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t1, t2, lat, n;
    key_valid = 1'b1; out_ready = 1'b1;
    ct_cur = FIPS_CT;
    clear_mon();
    start_valid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ld_en && n < 100);
    t1 = ld_en ? cyc : -1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ld_en && n < 200);
    t2 = ld_en ? cyc : -1000;
    start_valid = 1'b0;
    total++;
    if (t2 - t1 !== LAT + 2) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, LAT + 2); end
    wait_done(t2, lat);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    total++;
    if (ark_r !== FIPS_PT) begin bad++; $display("FAIL b2b_plaintext: got %h want %h", ark_r, FIPS_PT); end
    total++;
    if ({n_ark, n_isr, n_imc} !== {32'(2 * NR + 2), 32'(2 * NR), 32'(2 * NR - 2)}) begin
      bad++;
      $display("FAIL b2b_counts: got ark=%0d isr=%0d imc=%0d want %0d %0d %0d",
               n_ark, n_isr, n_imc, 2 * NR + 2, 2 * NR, 2 * NR - 2);
    end
    total++;
    if (sel_bad !== 0) begin bad++; $display("FAIL b2b_selects: got %0d bad selects want 0", sel_bad); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int t, n, k, lat;
    logic [127:0] ct;
    logic r_or;
    for (int op = 0; op < 4; op++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      key_valid = 1'b1; out_ready = 1'b0;
      start_op(ct, t);
      n = 0;
      while (!out_valid && n < 400) begin
        key_valid = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1; n++;
      end
      lat = out_valid ? cyc - t : -1;
      total++;
      if (lat !== LAT + n_stall) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", op, lat, LAT + n_stall); end
      total++;
      if (ark_r !== aes_dec(ct)) begin bad++; $display("FAIL rand_plaintext[%0d]: got %h want %h", op, ark_r, aes_dec(ct)); end
      total++;
      if (onehot_bad !== 0 || sel_bad !== 0) begin
        bad++;
        $display("FAIL rand_onehot_sel[%0d]: got onehot_bad=%0d sel_bad=%0d want 0 0", op, onehot_bad, sel_bad);
      end
      k = 0;
      while (out_valid && k < 20) begin
        r_or = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready = r_or;
        @(posedge clk); #1; k++;
        total++;
        if (out_valid !== !r_or) begin
          bad++;
          $display("FAIL rand_handshake[%0d]: got out_valid=%b want %b", op, out_valid, !r_or);
        end
      end
    end
    key_valid = 1'b1; out_ready = 1'b1;
  endtask

  initial begin
    build_tables();
    clear_mon();
    test_reset();
    test_basic();
    total++;
    if (onehot_bad !== 0) begin bad++; $display("FAIL onehot_basic: got %0d cycles want 0", onehot_bad); end
    test_key_stall();
    test_out_hold();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (onehot_bad !== 0) begin bad++; $display("FAIL onehot_b2b: got %0d cycles want 0", onehot_bad); end
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_round_ctrl.md
# aes_dec_round_ctrl

Round sequencer for the AES-256 decryption datapath. Accepts a start request and steps the inverse-round stages in the standard order: AddRoundKey, InvShiftRows, InvSubBytes and InvMixColumns. For each stage it issues one write enable, the operand-select signals and the round-key index requested from the key schedule. It holds the result with a valid/ready handshake until the consumer takes it. It contains no 128-bit data; it drives only the stage registers' enables and muxes.

## Interface
- NR, 14, number of rounds; legal values 10, 12, 14; round counter is 4 bits
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start_valid  in  1  ciphertext present on datapath input
- start_ready  out  1  controller idle, will accept start
- key_valid  in  1  round key for key_idx is available
- out_ready  in  1  consumer takes plaintext
- out_valid  out  1  plaintext stable on AddRoundKey register output
- busy  out  1  high in every state except IDLE
- round  out  4  current round, 0..NR
- key_idx  out  4  round-key index, equal to NR − round
- ld_en  out  1  load input register with ciphertext
- ark_en  out  1  AddRoundKey stage write enable
- isr_en  out  1  InvShiftRows stage write enable
- isb_en  out  1  InvSubBytes stage write enable
- imc_en  out  1  InvMixColumns stage wr_en
- ark_src  out  1  AddRoundKey operand: 0 = input register, 1 = InvSubBytes output
- isr_src  out  1  InvShiftRows operand: 0 = AddRoundKey output, 1 = InvMixColumns output

## Operation
- States: IDLE, LOAD, ARK, ISR, ISB, IMC, DONE.
- All outputs are Moore outputs decoded from the registered state and the round counter, except ark_en, which is gated by key_valid.
- IDLE:
  - start_ready=1.
  - start_valid=1 moves to LOAD and sets round to 0.
- LOAD:
  - ld_en=1 for one cycle, then ARK.
- ARK:
  - ark_en = key_valid. The state holds while key_valid=0; round and key_idx stay stable.
  - When key_valid=1: if round==NR go to DONE; else go to ISR with round incremented by 1.
- ISR:
  - isr_en=1 for one cycle, then ISB.
  - isr_src=0 when round==1, otherwise 1.
- ISB:
  - isb_en=1 for one cycle, then ARK.
- After ARK, when 1 ≤ round ≤ NR−1, the state goes to IMC instead of ISR.
- IMC:
  - imc_en=1 for one cycle, then ISR with round incremented by 1.
- ARK exit rule in full: round==0 → ISR; 1 ≤ round ≤ NR−1 → IMC; round==NR → DONE.
- Operand selects:
  - ark_src=0 only when round==0, else 1.
  - key_idx = NR − round, computed combinationally in 4 bits.
- DONE:
  - out_valid=1, held until out_ready=1, then IDLE.
  - round is cleared to 0 on that exit.
- Start requests are ignored in any state other than IDLE, since start_ready=0 there.
- key_valid is a don't-care outside ARK.
- out_ready is a don't-care outside DONE.
- At most one of ld_en, ark_en, isr_en, isb_en and imc_en is high in any cycle.

## Timing
- Reset (resetn=0, asynchronous):
  - State goes to IDLE and round to 0.
  - All enables, out_valid and busy are 0.
  - start_ready=1 and key_idx=NR.
- Reset mid-operation aborts the block immediately. No partial out_valid is produced. The first edge after resetn rises finds the block in IDLE.
- Acceptance edge T is the edge where start_valid=1 and state is IDLE. LOAD occupies cycle T..T+1.
- With key_valid held at 1, DONE is entered at edge T + 4·NR + 1, i.e. T+57 for NR=14:
  - 1 cycle LOAD and 1 cycle initial ARK,
  - (NR−1) rounds × 4 cycles (ISR, ISB, ARK, IMC),
  - final round of 3 cycles (ISR, ISB, ARK).
- Each cycle with key_valid=0 while in ARK adds exactly one cycle of latency.
- If out_ready=1 when DONE is entered, out_valid is high for exactly one cycle.
- Back-to-back operations: the minimum spacing between acceptance edges is 4·NR+3 cycles, because one IDLE cycle is mandatory.
- Sequence of key_idx over one operation for NR=14: 14, 13, …, 1, 0. Each value is consumed by exactly one ark_en pulse.

## Test plan
- Reset, then one start with key_valid=1 and out_ready=1:
  - out_valid rises 57 cycles after the acceptance edge.
  - The counts of ark_en, isr_en, isb_en and imc_en pulses are 15, 14, 14 and 13.
  - Decrypting FIPS-197 C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 yields 00112233445566778899aabbccddeeff.
- key_valid low for 3 cycles in round 5 ARK:
  - ark_en stays 0 and round=5, key_idx=9 are held.
  - Total latency becomes 60 cycles.
- out_ready held 0 for 10 cycles in DONE:
  - out_valid stays 1 and start_ready stays 0.
  - A start_valid pulse during this window is ignored.
- resetn pulsed low during round 7 ISB:
  - All enables drop asynchronously and round=0.
  - The next start completes normally in 57 cycles.
- Two back-to-back starts with start_valid held 1 and out_ready=1:
  - The acceptance edges are 59 cycles apart.
  - The select sequence matches the rules above: isr_src=0 only at round 1, ark_src=0 only at round 0.
- One-hot check across all tests: at most one stage enable is high per cycle.
